// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl -- 8-bit GPIO controller driving a PB8-style pad ring.
// Registers: PORT (output latch), TRIS (1 = input), IMASK, IFLAG (W1C,
// rising-edge capture on input pins). Registered read path, registered irq.
// Optional build macro: GPIO_DEBOUNCE_EN -- adds a per-bit 4-clock
// stability filter between the synchronizer and the edge detector.
module gpio_pad_ctrl (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_addr,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_data,
    input  logic       i_rd_en,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_irq,
    output logic [7:0] o_pad_i,
    output logic [7:0] o_pad_oen,
    output logic [7:0] o_pad_ie,
    output logic [7:0] o_pad_pg,
    input  logic [7:0] i_pad_c
);

    localparam logic [1:0] ADDR_PORT  = 2'd0;
    localparam logic [1:0] ADDR_TRIS  = 2'd1;
    localparam logic [1:0] ADDR_IMASK = 2'd2;
    localparam logic [1:0] ADDR_IFLAG = 2'd3;

    logic [7:0] r_port;
    logic [7:0] r_tris;
    logic [7:0] r_imask;
    logic [7:0] r_iflag;
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_in_s_d;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;
    logic       r_irq;
    logic       r_pg_en;

    logic [7:0] w_in_s;
    logic [7:0] w_pin;
    logic [7:0] w_tris_next;
    logic [7:0] w_w1c;
    logic [7:0] w_rise;
    logic [7:0] w_iflag_next;
    logic [7:0] w_rd_mux;

    // Pad-facing outputs come straight from the control registers.
    assign o_pad_i    = r_port;
    assign o_pad_oen  = r_tris;
    assign o_pad_ie   = r_tris;
    assign o_pad_pg   = {8{r_pg_en}};
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_irq      = r_irq;

    // Pad power-good enable: low in reset, high from the first edge after.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_pg_en <= 1'b0;
        else         r_pg_en <= 1'b1;
    end

    // Two-flop synchronizer for the asynchronous pad receiver outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= i_pad_c;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    // Per-bit filter: in_s follows the synchronizer only after it has
    // disagreed for 4 consecutive clocks; any agreement restarts the count.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_debounce
            logic [1:0] r_cnt;
            logic       r_in_s;

            // Stability counter and filtered level for one pin.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_cnt  <= 2'd0;
                    r_in_s <= 1'b0;
                end else if (r_sync2[gi] == r_in_s) begin
                    r_cnt <= 2'd0;
                end else if (r_cnt == 2'd3) begin
                    r_cnt  <= 2'd0;
                    r_in_s <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end

            assign w_in_s[gi] = r_in_s;
        end
    endgenerate
`else
    assign w_in_s = r_sync2;
`endif

    // Delayed copy of in_s for rising-edge detection.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_in_s_d <= 8'h00;
        else         r_in_s_d <= w_in_s;
    end

    // Edge capture is allowed only where the pin is an input both before and
    // after this edge, so a TRIS change never manufactures a flag.
    always_comb begin
        w_tris_next  = (i_wr_en && i_addr == ADDR_TRIS) ? i_wr_data : r_tris;
        w_w1c        = (i_wr_en && i_addr == ADDR_IFLAG) ? i_wr_data : 8'h00;
        w_rise       = w_in_s & ~r_in_s_d & r_tris & w_tris_next;
        w_iflag_next = (r_iflag & ~w_w1c) | w_rise;
        w_pin        = (r_tris & w_in_s) | (~r_tris & r_port);
    end

    // Register read mux; samples pre-write values so a same-cycle write
    // does not bypass into the read.
    always_comb begin
        w_rd_mux = 8'h00;
        case (i_addr)
            ADDR_PORT:  w_rd_mux = w_pin;
            ADDR_TRIS:  w_rd_mux = r_tris;
            ADDR_IMASK: w_rd_mux = r_imask;
            ADDR_IFLAG: w_rd_mux = r_iflag;
            default:    w_rd_mux = 8'h00;
        endcase
    end

    // Control register writes and interrupt flag update.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_port  <= 8'h00;
            r_tris  <= 8'hFF;
            r_imask <= 8'h00;
            r_iflag <= 8'h00;
        end else begin
            if (i_wr_en && i_addr == ADDR_PORT)  r_port  <= i_wr_data;
            if (i_wr_en && i_addr == ADDR_IMASK) r_imask <= i_wr_data;
            r_tris  <= w_tris_next;
            r_iflag <= w_iflag_next;
        end
    end

    // Read response: one-cycle valid pulse, data held between reads.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) r_rd_data <= w_rd_mux;
        end
    end

    // Interrupt output, one cycle behind the flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_irq <= 1'b0;
        else         r_irq <= |(r_iflag & r_imask);
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl -- directed bench for gpio_pad_ctrl. Read responses are
// checked by a scoreboard monitor; pad/irq levels are checked inline.
// Honors GPIO_DEBOUNCE_EN to select the expected edge-capture latency.
module tb_gpio_pad_ctrl;

`ifdef GPIO_DEBOUNCE_EN
    localparam int FLAG_LAT = 7;
`else
    localparam int FLAG_LAT = 3;
`endif
    localparam int SETTLE = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       irq;
    logic [7:0] pad_i;
    logic [7:0] pad_oen;
    logic [7:0] pad_ie;
    logic [7:0] pad_pg;
    logic [7:0] pad_c;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    gpio_pad_ctrl dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_addr    (addr),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_rd_en   (rd_en),
        .o_rd_data (rd_data),
        .o_rd_valid(rd_valid),
        .o_irq     (irq),
        .o_pad_i   (pad_i),
        .o_pad_oen (pad_oen),
        .o_pad_ie  (pad_ie),
        .o_pad_pg  (pad_pg),
        .i_pad_c   (pad_c)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every rd_valid pops one expected read value.
    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid=1 data=%02h, required no response", rd_data);
            end else begin
                logic [7:0] e;
                string      nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL %s: rd_data=%02h, required %02h", nm, rd_data, e);
                end else begin
                    $display("read %s: rd_data=%02h ok", nm, rd_data);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, required %02h", nm, act, exp);
        end else begin
            $display("check %s: %02h ok", nm, act);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; wr_data = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm);
        addr = a; rd_en = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = 2'd0; wr_en = 1'b0; wr_data = 8'h00;
        rd_en = 1'b0; pad_c = 8'h00;
        tick(3);

        // Reset state
        chk("rst_oen",   pad_oen, 8'hFF);
        chk("rst_ie",    pad_ie,  8'hFF);
        chk("rst_pad_i", pad_i,   8'h00);
        chk("rst_pg",    pad_pg,  8'h00);
        chk("rst_irq",   {7'd0, irq}, 8'h00);
        chk("rst_rdata", rd_data, 8'h00);
        reset = 1'b0;
        tick();
        chk("pg_on", pad_pg, 8'hFF);

        rd(2'd1, 8'hFF, "tris_rst");
        rd(2'd2, 8'h00, "imask_rst");
        rd(2'd3, 8'h00, "iflag_rst");
        rd(2'd0, 8'h00, "pin_rst");

        // Pad drive
        wr(2'd1, 8'h0F);
        wr(2'd0, 8'hA5);
        chk("pad_oen", pad_oen, 8'h0F);
        chk("pad_ie",  pad_ie,  8'h0F);
        chk("pad_i",   pad_i,   8'hA5);
        chk("pad_pg",  pad_pg,  8'hFF);

        // Pin value mixes synchronized inputs with PORT on outputs
        pad_c = 8'h03;
        tick(SETTLE);
        rd(2'd0, 8'hA3, "pin_mix");
        rd(2'd3, 8'h03, "iflag_in_edges");
        tick(3);
        chk("rd_hold", rd_data, 8'h03);
        wr(2'd3, 8'hFF);
        rd(2'd3, 8'h00, "iflag_w1c_all");

        // Same-cycle read and write of IMASK returns the old value
        addr = 2'd2; wr_data = 8'h01; wr_en = 1'b1; rd_en = 1'b1;
        exp_q.push_back(8'h00); name_q.push_back("imask_rw_same");
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        rd(2'd2, 8'h01, "imask_new");

        // Edge-to-flag and flag-to-irq latency
        pad_c = 8'h00;
        tick(SETTLE);
        pad_c = 8'h01;
        tick(FLAG_LAT);
        chk("irq_before", {7'd0, irq}, 8'h00);
        rd(2'd3, 8'h01, "iflag_edge0");
        chk("irq_rise", {7'd0, irq}, 8'h01);
        wr(2'd3, 8'h01);
        chk("irq_hold_w1c", {7'd0, irq}, 8'h01);
        tick();
        chk("irq_clear", {7'd0, irq}, 8'h00);

        // Set wins over W1C on the same edge
        pad_c = 8'h00;
        tick(SETTLE);
        pad_c = 8'h01;
        tick(FLAG_LAT - 1);
        wr(2'd3, 8'h01);
        rd(2'd3, 8'h01, "set_wins");
        wr(2'd3, 8'h01);
        rd(2'd3, 8'h00, "iflag_cleared");

        // Toggling an output pin never flags
        for (int k = 0; k < 3; k++) begin
            pad_c = 8'h81; tick(SETTLE);
            pad_c = 8'h01; tick(SETTLE);
        end
        rd(2'd3, 8'h00, "out_pin_noflag");
        chk("irq_out_pin", {7'd0, irq}, 8'h00);

`ifdef GPIO_DEBOUNCE_EN
        // Short glitch filtered, long pulse captured
        pad_c = 8'h03; tick(2); pad_c = 8'h01; tick(SETTLE);
        rd(2'd3, 8'h00, "glitch2_noflag");
        pad_c = 8'h03; tick(6); pad_c = 8'h01; tick(SETTLE);
        rd(2'd3, 8'h02, "pulse6_flag");
`else
        // Without filtering a one-cycle pulse is captured
        pad_c = 8'h03; tick(1); pad_c = 8'h01; tick(SETTLE);
        rd(2'd3, 8'h02, "pulse1_flag");
`endif

        // Reset during a read cancels the response
        addr = 2'd1; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_cancel_valid", {7'd0, rd_valid}, 8'h00);
        chk("rst_async_oen", pad_oen, 8'hFF);
        chk("rst_async_pad_i", pad_i, 8'h00);
        tick(2);
        reset = 1'b0;
        tick(4);

        chk("sb_drain", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/gpio_pad_ctrl.md
GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high; one clock, asynchronous active-high reset, no other reset.
REQ-003 SHALL: addr  input  2  register select: 0 PORT, 1 TRIS, 2 IMASK, 3 IFLAG.
REQ-004 SHALL: wr_en  input  1  write strobe, one write per asserted cycle.
REQ-005 SHALL: wr_data  input  8  write data.
REQ-006 SHALL: rd_en  input  1  read request.
REQ-007 SHALL: rd_data  output  8  registered read data.
REQ-008 SHALL: rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-009 SHALL: irq  output  1  registered OR of (IFLAG & IMASK).
REQ-010 SHALL: pad_i  output  8  to PB8 I, the output value.
REQ-011 SHALL: pad_oen  output  8  to PB8 OEN; 1 = driver off.
REQ-012 SHALL: pad_ie  output  8  to PB8 IE; 1 = receiver on.
REQ-013 SHALL: pad_pg  output  8  to PB8 PG; 1 = pad enabled.
REQ-014 SHALL: pad_c  input  8  from PB8 C; asynchronous to clk.

Function
REQ-015 SHALL: PORT latch drive pad_i directly; TRIS drive pad_oen and pad_ie directly (TRIS bit 1 = input pin, 0 = output pin).
REQ-016 SHALL: pad_pg come from a single enable flop, 0 in reset, 1 on the first clk edge after reset deasserts, applied to all 8 bits.
REQ-017 SHALL: pad_c pass a 2-flop synchronizer; synchronized value is in_s, with in_s_d its one-cycle delayed copy.
REQ-018 SHALL: pin value = TRIS ? in_s : PORT, per bit.
REQ-019 SHALL: rd_en in cycle N give rd_data and rd_valid=1 in cycle N+1; addr 0 returns the pin value, 1 TRIS, 2 IMASK, 3 IFLAG; rd_data holds its value when rd_valid=0.
REQ-020 SHALL: rd_en and wr_en in the same cycle to the same addr return the pre-write value.
REQ-021 SHALL: a write to addr 0/1/2 load PORT/TRIS/IMASK on that clk edge; the pad outputs change the same edge.
REQ-022 SHALL: a write to addr 3 clear each IFLAG bit where wr_data is 1 (write-1-to-clear); bits where wr_data is 0 are unchanged.
REQ-023 SHALL: IFLAG[k] set when in_s[k]=1, in_s_d[k]=0 and TRIS[k]=1 (rising edge on an input pin).
REQ-024 SHALL: simultaneous set and W1C on the same bit leave the bit set (set wins).
REQ-025 SHALL: edges on output pins (TRIS=0) never set IFLAG, including the cycle TRIS changes.
REQ-026 SHALL: irq = registered |(IFLAG & IMASK), so it rises one cycle after the flag sets.
REQ-027 SHALL: pad_c rising at edge E set IFLAG at E+3 and irq at E+4 (no debounce).

Reset
REQ-028 SHALL: reset force PORT=0x00, TRIS=0xFF, IMASK=0x00, IFLAG=0x00, synchronizer/in_s/in_s_d=0, rd_data=0x00, rd_valid=0, irq=0, pg enable=0, asynchronously.
REQ-029 SHALL: reset mid-read cancel the pending rd_valid; reset mid-edge-detect set no IFLAG bit.
REQ-030 SHALL: in reset, pad_oen=0xFF, pad_ie=0xFF, pad_i=0x00, pad_pg=0x00.

Configuration
REQ-031 SHALL: with GPIO_DEBOUNCE_EN defined, each bit have a 2-bit stability counter, and in_s[k] take the synchronizer output only after it has differed from in_s[k] for 4 consecutive clocks; any reversal resets the counter to 0.
REQ-032 SHALL: with GPIO_DEBOUNCE_EN defined, the REQ-027 latency become IFLAG at E+7 and irq at E+8; glitches under 4 cycles produce no flag.
REQ-033 SHALL: without GPIO_DEBOUNCE_EN, in_s be the synchronizer's second-stage output and no counters exist.

Verification
REQ-034 SHALL: reset, then write TRIS=0x0F and PORT=0xA5 -> pad_oen=0x0F, pad_ie=0x0F, pad_i=0xA5, pad_pg=0xFF.
REQ-035 SHALL: TRIS=0x0F, pad_c=0x03, then rd_en with addr 0 -> rd_data=0xA3 one cycle later, rd_valid high for exactly 1 cycle.
REQ-036 SHALL: IMASK=0x01, pad_c[0] 0->1 -> IFLAG=0x01 at E+3, irq=1 at E+4; write addr 3 data 0x01 -> irq=0 two edges later.
REQ-037 SHALL: W1C of bit 0 in the same cycle a new rising edge sets it -> IFLAG[0] stays 1.
REQ-038 SHALL: pad_c[7] toggling with TRIS[7]=0 -> IFLAG[7] stays 0.
REQ-039 SHALL: GPIO_DEBOUNCE_EN defined, 2-cycle pulse on pad_c[1] -> no flag; 6-cycle pulse -> IFLAG[1]=1.
